// File: rtl/rx_udp_buf_ctrl.sv
// rtl/rx_udp_buf_ctrl.sv - ping-pong RX payload buffer sequencer for UDP datagrams
// Allocates a free bank per datagram, writes bytes, commits length/port and holds the bank until released.
module rx_udp_buf_ctrl #(
  parameter int OCT    = 8,
  parameter int ADDR_W = 11
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              rx_udp_data_v,
  input  logic [OCT-1:0]    rx_udp_data,
  input  logic              rx_port_match,
  input  logic [2*OCT-1:0]  rx_src_port,
  input  logic [1:0]        host_release,
  output logic              buf_we,
  output logic              buf_bank,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [OCT-1:0]    buf_wdata,
  output logic [1:0]        bank_full,
  output logic [2*OCT-1:0]  bank_len0,
  output logic [2*OCT-1:0]  bank_len1,
  output logic [2*OCT-1:0]  bank_port0,
  output logic [2*OCT-1:0]  bank_port1,
  output logic              rx_buf_irq,
  output logic [2*OCT-1:0]  drop_cnt
);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FILL, S_DROP} state_t;

  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state, w_next;
  logic                r_nxt_bank, r_bank;
  logic [ADDR_W:0]     r_wr_cnt;
  logic [2*OCT-1:0]    r_port;
  logic                r_buf_we, r_buf_bank, r_irq;
  logic [ADDR_W-1:0]   r_buf_addr;
  logic [OCT-1:0]      r_buf_wdata;
  logic [1:0]          r_bank_full;
  logic [2*OCT-1:0]    r_len0, r_len1, r_port0, r_port1, r_drop_cnt;

  logic                w_both_full, w_cnt_full, w_alloc_bank;
  logic                w_start, w_wr, w_commit, w_drop_inc, w_wr_bank;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [1:0]          w_commit_mask;

  assign w_both_full  = &r_bank_full;
  assign w_cnt_full   = (r_wr_cnt == C_DEPTH);
  assign w_alloc_bank = r_bank_full[r_nxt_bank] ? ~r_nxt_bank : r_nxt_bank;

  always_ff @(posedge RX_CLK) begin
    if (rst) r_state <= S_SYNC;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SYNC: if (!rx_udp_data_v) w_next = S_IDLE;
      S_IDLE: if (rx_udp_data_v) w_next = (rx_port_match && !w_both_full) ? S_FILL : S_DROP;
      S_FILL: begin
        if (!rx_udp_data_v)  w_next = S_IDLE;
        else if (w_cnt_full) w_next = S_DROP;
      end
      S_DROP: if (!rx_udp_data_v) w_next = S_IDLE;
      default: w_next = S_SYNC;
    endcase
  end

  always_comb begin
    w_start    = (r_state == S_IDLE) && rx_udp_data_v && rx_port_match && !w_both_full;
    w_wr       = w_start || ((r_state == S_FILL) && rx_udp_data_v && !w_cnt_full);
    w_commit   = (r_state == S_FILL) && !rx_udp_data_v;
    w_drop_inc = ((r_state == S_IDLE) && rx_udp_data_v && rx_port_match && w_both_full) ||
                 ((r_state == S_FILL) && rx_udp_data_v && w_cnt_full);
    w_wr_bank  = w_start ? w_alloc_bank : r_bank;
    w_wr_addr  = w_start ? '0 : r_wr_cnt[ADDR_W-1:0];
    w_commit_mask = 2'b00;
    if (w_commit) w_commit_mask = r_bank ? 2'b10 : 2'b01;
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      r_nxt_bank  <= 1'b0;
      r_bank      <= 1'b0;
      r_wr_cnt    <= '0;
      r_port      <= '0;
      r_buf_we    <= 1'b0;
      r_buf_bank  <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
      r_irq       <= 1'b0;
      r_bank_full <= 2'b00;
      r_len0      <= '0;
      r_len1      <= '0;
      r_port0     <= '0;
      r_port1     <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_buf_we <= w_wr;
      if (w_wr) begin
        r_buf_bank  <= w_wr_bank;
        r_buf_addr  <= w_wr_addr;
        r_buf_wdata <= rx_udp_data;
      end
      if (w_start) begin
        r_bank   <= w_alloc_bank;
        r_wr_cnt <= {{ADDR_W{1'b0}}, 1'b1};
        r_port   <= rx_src_port;
      end else if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      r_irq <= w_commit;
      if (w_commit) begin
        r_nxt_bank <= ~r_bank;
        if (r_bank) begin
          r_len1  <= (2*OCT)'(r_wr_cnt);
          r_port1 <= r_port;
        end else begin
          r_len0  <= (2*OCT)'(r_wr_cnt);
          r_port0 <= r_port;
        end
      end
      // A release seen this cycle only frees the bank for allocations from the next cycle on.
      r_bank_full <= (r_bank_full & ~host_release) | w_commit_mask;
      if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign buf_we     = r_buf_we;
  assign buf_bank   = r_buf_bank;
  assign buf_addr   = r_buf_addr;
  assign buf_wdata  = r_buf_wdata;
  assign bank_full  = r_bank_full;
  assign bank_len0  = r_len0;
  assign bank_len1  = r_len1;
  assign bank_port0 = r_port0;
  assign bank_port1 = r_port1;
  assign rx_buf_irq = r_irq;
  assign drop_cnt   = r_drop_cnt;

endmodule
